// File: rtl/wall_spawn_scheduler.sv
// wall_spawn_scheduler
//   Shares one LFSR-based random position source between NUM_WALLS wall slots.
//   Pending respawn requests are served one at a time in round-robin order. For
//   each grant the shared LFSR is stepped, the sample is rejection-tested
//   against the on-screen keep-out border, and the accepted (or centre
//   fallback) position is committed to the granted slot.
//
// Ports
//   pixel_clk    in   single clock, all state on posedge
//   rst          in   synchronous active-high reset
//   respawn_req  in   per-slot request, sticky once sampled
//   rnd_x/rnd_y  in   LFSR data, valid the cycle after rnd_en
//   rnd_en       out  steps both LFSRs one position
//   respawn_ack  out  one-cycle one-hot pulse when a slot is committed
//   wall_valid   out  slot holds committed coordinates
//   wall_x/y     out  packed slot coordinates, slot i at [11*i+10:11*i]
//   busy         out  scheduler is not idle
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for any pending request
// S_ARB     | round-robin pick of the next pending slot
// S_SAMPLE  | pulse rnd_en to step the LFSRs
// S_CAPTURE | register the fresh LFSR sample as candidate
// S_CHECK   | accept, retry, or fall back to screen centre
// S_COMMIT  | write candidate to granted slot, pulse ack
// S_GAP     | hold off SPAWN_GAP cycles before the next grant

module wall_spawn_scheduler #(
    parameter int NUM_WALLS = 4,
    parameter int H_MAX     = 640,
    parameter int V_MAX     = 480,
    parameter int MARGIN    = 16,
    parameter int MAX_TRIES = 8,
    parameter int SPAWN_GAP = 60
) (
    input  logic                   pixel_clk,
    input  logic                   rst,
    input  logic [NUM_WALLS-1:0]   respawn_req,
    input  logic [10:0]            rnd_x,
    input  logic [10:0]            rnd_y,
    output logic                   rnd_en,
    output logic [NUM_WALLS-1:0]   respawn_ack,
    output logic [NUM_WALLS-1:0]   wall_valid,
    output logic [11*NUM_WALLS-1:0] wall_x,
    output logic [11*NUM_WALLS-1:0] wall_y,
    output logic                   busy
);

    localparam int GW = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;
    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam int CW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

    localparam logic [10:0] X_LO  = 11'(MARGIN);
    localparam logic [10:0] X_HI  = 11'(H_MAX - MARGIN);
    localparam logic [10:0] Y_LO  = 11'(MARGIN);
    localparam logic [10:0] Y_HI  = 11'(V_MAX - MARGIN);
    localparam logic [10:0] X_MID = 11'(H_MAX / 2);
    localparam logic [10:0] Y_MID = 11'(V_MAX / 2);

    localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);
    // Down-counter reload: GAP state lasts exactly SPAWN_GAP cycles.
    localparam logic [CW-1:0] GAP_LOAD   = CW'((SPAWN_GAP > 0) ? SPAWN_GAP - 1 : 0);
    localparam logic [GW-1:0] GRANT_INIT = GW'(NUM_WALLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SAMPLE,
        S_CAPTURE,
        S_CHECK,
        S_COMMIT,
        S_GAP
    } state_t;

    state_t state, state_nxt;

    logic [NUM_WALLS-1:0] pending;
    logic [NUM_WALLS-1:0] commit_mask;
    logic [GW-1:0]        grant;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        rr_pick;
    logic                 rr_found;
    int                   rr_idx;
    logic [TW-1:0]        tries;
    logic [CW-1:0]        gap_cnt;
    logic [10:0]          cand_x;
    logic [10:0]          cand_y;
    logic                 cand_legal;

    // Zero is the LFSR lock-up value and is never accepted, even if the
    // border were configured to allow it.
    assign cand_legal = (cand_x >= X_LO) && (cand_x < X_HI) &&
                        (cand_y >= Y_LO) && (cand_y < Y_HI) &&
                        ((cand_x | cand_y) != 11'd0);

    assign commit_mask = (state == S_COMMIT) ? (NUM_WALLS'(1) << grant) : '0;
    assign busy        = (state != S_IDLE);

    // Search starts one past the previous grant and wraps.
    always_comb begin
        rr_pick  = last_grant;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int i = 1; i <= NUM_WALLS; i++) begin
            rr_idx = (int'(last_grant) + i) % NUM_WALLS;
            if (!rr_found && pending[rr_idx]) begin
                rr_pick  = GW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rnd_en    = 1'b0;
        case (state)
            S_IDLE:    if (pending != '0) state_nxt = S_ARB;
            S_ARB:     state_nxt = S_SAMPLE;
            S_SAMPLE: begin
                rnd_en    = 1'b1;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: state_nxt = S_CHECK;
            S_CHECK: begin
                if (cand_legal || (tries >= TRIES_LAST)) state_nxt = S_COMMIT;
                else                                     state_nxt = S_SAMPLE;
            end
            S_COMMIT:  state_nxt = (SPAWN_GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:     if (gap_cnt == '0) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pending     <= '0;
            respawn_ack <= '0;
            wall_valid  <= '0;
            wall_x      <= '0;
            wall_y      <= '0;
            grant       <= '0;
            last_grant  <= GRANT_INIT;
            tries       <= '0;
            gap_cnt     <= '0;
            cand_x      <= '0;
            cand_y      <= '0;
        end else begin
            respawn_ack <= '0;
            // A request arriving on the commit edge for the same slot survives.
            pending     <= (pending & ~commit_mask) | respawn_req;
            case (state)
                S_ARB: grant <= rr_pick;
                S_CAPTURE: begin
                    cand_x <= rnd_x;
                    cand_y <= rnd_y;
                end
                S_CHECK: begin
                    if (!cand_legal) begin
                        if (tries < TRIES_LAST) begin
                            tries <= tries + 1'b1;
                        end else begin
                            cand_x <= X_MID;
                            cand_y <= Y_MID;
                        end
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < NUM_WALLS; i++) begin
                        if (commit_mask[i]) begin
                            wall_x[11*i +: 11] <= cand_x;
                            wall_y[11*i +: 11] <= cand_y;
                            wall_valid[i]      <= 1'b1;
                        end
                    end
                    respawn_ack <= commit_mask;
                    last_grant  <= grant;
                    tries       <= '0;
                    gap_cnt     <= GAP_LOAD;
                end
                S_GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wall_spawn_scheduler.sv
module tb_wall_spawn_scheduler;

    localparam int NW        = 4;
    localparam int H_MAX     = 640;
    localparam int V_MAX     = 480;
    localparam int MARGIN    = 16;
    localparam int MAX_TRIES = 8;
    localparam int GAP       = 4;
    localparam int SN        = 4096;

    logic               pixel_clk = 1'b0;
    logic               rst = 1'b1;
    logic [NW-1:0]      respawn_req = '0;
    logic [10:0]        rnd_x = '0;
    logic [10:0]        rnd_y = '0;
    logic               rnd_en;
    logic [NW-1:0]      respawn_ack;
    logic [NW-1:0]      wall_valid;
    logic [11*NW-1:0]   wall_x;
    logic [11*NW-1:0]   wall_y;
    logic               busy;

    wall_spawn_scheduler #(
        .NUM_WALLS(NW), .H_MAX(H_MAX), .V_MAX(V_MAX), .MARGIN(MARGIN),
        .MAX_TRIES(MAX_TRIES), .SPAWN_GAP(GAP)
    ) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .respawn_req(respawn_req),
        .rnd_x      (rnd_x),
        .rnd_y      (rnd_y),
        .rnd_en     (rnd_en),
        .respawn_ack(respawn_ack),
        .wall_valid (wall_valid),
        .wall_x     (wall_x),
        .wall_y     (wall_y),
        .busy       (busy)
    );

    always #5 pixel_clk = ~pixel_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- LFSR stand-in: a pre-drawn sample stream ----------------
    logic [10:0] sx[SN];
    logic [10:0] sy[SN];
    int          drv_idx = 0;
    bit          en_seen = 0;

    function automatic logic [10:0] rnd_coord(input int vmax);
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 11'($urandom_range(MARGIN, vmax - MARGIN - 1));
        if (r < 8) return 11'($urandom_range(0, 2047));
        if (r == 8) begin
            case ($urandom_range(0, 3))
                0: return 11'(MARGIN - 1);
                1: return 11'(MARGIN);
                2: return 11'(vmax - MARGIN - 1);
                default: return 11'(vmax - MARGIN);
            endcase
        end
        return 11'd0;
    endfunction

    task automatic put(input int j, input int x, input int y);
        sx[(drv_idx + j) % SN] = 11'(x);
        sy[(drv_idx + j) % SN] = 11'(y);
    endtask

    always @(negedge pixel_clk) en_seen = (rnd_en === 1'b1);

    always @(posedge pixel_clk) begin
        if (en_seen) begin
            #1;
            rnd_x = sx[drv_idx % SN];
            rnd_y = sy[drv_idx % SN];
            drv_idx++;
        end
    end

    // ---------------- Behavioural model (transaction timeline) ----------------
    function automatic bit legal(input logic [10:0] x, input logic [10:0] y);
        return (int'(x) >= MARGIN) && (int'(x) < H_MAX - MARGIN) &&
               (int'(y) >= MARGIN) && (int'(y) < V_MAX - MARGIN) &&
               !(x == 0 && y == 0);
    endfunction

    int          ecount = 0;
    bit          model_ok = 0;
    logic [NW-1:0] m_pend, m_valid, m_ack;
    logic [10:0] m_x[NW];
    logic [10:0] m_y[NW];
    int          m_last;
    bit          job = 0, arb_sched = 0;
    int          arb_at, commit_at, idle_from = 0, jg, jk;
    logic [10:0] jx, jy;

    always @(posedge pixel_clk) begin : model
        logic [NW-1:0] clr;
        bit            got;
        ecount++;
        m_ack = '0;
        if (rst) begin
            m_pend = '0; m_valid = '0;
            for (int i = 0; i < NW; i++) begin m_x[i] = '0; m_y[i] = '0; end
            m_last = NW - 1; job = 0; arb_sched = 0; idle_from = ecount;
            model_ok = 1;
        end else begin
            clr = '0;
            if (job && ecount == commit_at) begin
                m_x[jg] = jx; m_y[jg] = jy; m_valid[jg] = 1'b1; m_ack[jg] = 1'b1;
                clr[jg] = 1'b1; m_last = jg; job = 0; idle_from = commit_at + GAP;
            end
            m_pend = (m_pend & ~clr) | respawn_req;
            if (arb_sched && ecount == arb_at) begin
                arb_sched = 0; job = 1; jg = -1;
                for (int i = 1; i <= NW; i++)
                    if (jg < 0 && m_pend[(m_last + i) % NW]) jg = (m_last + i) % NW;
                got = 0; jk = MAX_TRIES; jx = 11'(H_MAX / 2); jy = 11'(V_MAX / 2);
                for (int j = 0; j < MAX_TRIES; j++) begin
                    if (!got && legal(sx[(drv_idx + j) % SN], sy[(drv_idx + j) % SN])) begin
                        got = 1; jk = j + 1;
                        jx = sx[(drv_idx + j) % SN]; jy = sy[(drv_idx + j) % SN];
                    end
                end
                commit_at = arb_at + 5 + 3 * (jk - 1);
            end else if (!job && !arb_sched && ecount >= idle_from && m_pend != '0) begin
                arb_sched = 1; arb_at = ecount + 1;
            end
        end
    end

    always @(negedge pixel_clk) begin : compare
        bit m_busy, m_rnd;
        int d;
        if (model_ok) begin
            d      = ecount - arb_at - 1;
            m_busy = job || (ecount < idle_from);
            m_rnd  = job && (d >= 0) && (d % 3 == 0) && (d / 3 < jk);
            chk("rnd_en", 32'(rnd_en), 32'(m_rnd));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("respawn_ack", 32'(respawn_ack), 32'(m_ack));
            chk("wall_valid", 32'(wall_valid), 32'(m_valid));
            for (int i = 0; i < NW; i++) begin
                chk($sformatf("wall_x[%0d]", i), 32'(wall_x[11*i +: 11]), 32'(m_x[i]));
                chk($sformatf("wall_y[%0d]", i), 32'(wall_y[11*i +: 11]), 32'(m_y[i]));
            end
        end
    end

    // ---------------- Directed helpers ----------------
    int ack_n[$];
    int ack_s[$];
    int nrnd;

    task automatic pulse(input logic [NW-1:0] m);
        respawn_req = m;
        @(negedge pixel_clk);
        respawn_req = '0;
    endtask

    task automatic watch(input int ncyc);
        ack_n.delete(); ack_s.delete(); nrnd = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge pixel_clk);
            if (rnd_en === 1'b1) nrnd++;
            if (respawn_ack !== '0) begin
                ack_n.push_back(n);
                ack_s.push_back(int'(respawn_ack));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < SN; i++) begin
            sx[i] = rnd_coord(H_MAX);
            sy[i] = rnd_coord(V_MAX);
        end

        // T1 reset
        @(posedge pixel_clk); @(posedge pixel_clk); @(negedge pixel_clk);
        chk("t1_rnd_en", 32'(rnd_en), 0);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_ack", 32'(respawn_ack), 0);
        chk("t1_valid", 32'(wall_valid), 0);
        chk("t1_wall_x", wall_x[31:0], 0);
        chk("t1_wall_y", wall_y[31:0], 0);
        rst = 1'b0;
        @(negedge pixel_clk);

        // T2 single request, first sample legal
        put(0, 100, 200);
        pulse(4'b0100);
        watch(12);
        chk("t2_ack_count", ack_n.size(), 1);
        if (ack_n.size() > 0) begin
            chk("t2_ack_cycle", ack_n[0], 6);
            chk("t2_ack_slot", ack_s[0], 4);
        end
        chk("t2_rnd_pulses", nrnd, 1);
        chk("t2_x", 32'(wall_x[22 +: 11]), 100);
        chk("t2_y", 32'(wall_y[22 +: 11]), 200);
        chk("t2_valid", 32'(wall_valid), 4);
        chk("t2_idle", 32'(busy), 0);

        // T3 one reject then accept
        put(0, 700, 50); put(1, 300, 300);
        pulse(4'b0010);
        watch(16);
        chk("t3_ack_count", ack_n.size(), 1);
        if (ack_n.size() > 0) chk("t3_ack_cycle", ack_n[0], 9);
        chk("t3_rnd_pulses", nrnd, 2);
        chk("t3_x", 32'(wall_x[11 +: 11]), 300);
        chk("t3_y", 32'(wall_y[11 +: 11]), 300);

        // T4 all rejects, centre fallback
        for (int j = 0; j < 8; j++) put(j, 5, 5);
        pulse(4'b1000);
        watch(34);
        chk("t4_ack_count", ack_n.size(), 1);
        if (ack_n.size() > 0) chk("t4_ack_cycle", ack_n[0], 27);
        chk("t4_rnd_pulses", nrnd, 8);
        chk("t4_x", 32'(wall_x[33 +: 11]), 320);
        chk("t4_y", 32'(wall_y[33 +: 11]), 240);
        chk("t4_valid", 32'(wall_valid), 14);

        // T5 simultaneous requests, round-robin from slot 0
        put(0, 50, 60); put(1, 70, 80); put(2, 90, 100);
        pulse(4'b1011);
        watch(34);
        chk("t5_ack_count", ack_n.size(), 3);
        if (ack_n.size() == 3) begin
            chk("t5_ack0_slot", ack_s[0], 1);
            chk("t5_ack1_slot", ack_s[1], 2);
            chk("t5_ack2_slot", ack_s[2], 8);
            chk("t5_gap01", ack_n[1] - ack_n[0], 10);
            chk("t5_gap12", ack_n[2] - ack_n[1], 10);
        end
        chk("t5_x0", 32'(wall_x[0 +: 11]), 50);
        chk("t5_y1", 32'(wall_y[11 +: 11]), 80);
        chk("t5_x3", 32'(wall_x[33 +: 11]), 90);
        chk("t5_slot2_x", 32'(wall_x[22 +: 11]), 100);
        chk("t5_slot2_y", 32'(wall_y[22 +: 11]), 200);

        // T6 reset while in CAPTURE
        put(0, 123, 45);
        pulse(4'b0001);
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        chk("t6_sample_rnd_en", 32'(rnd_en), 1);
        @(negedge pixel_clk);
        rst = 1'b1;
        @(negedge pixel_clk);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_ack", 32'(respawn_ack), 0);
        chk("t6_valid", 32'(wall_valid), 0);
        chk("t6_wall_x", wall_x[31:0], 0);
        chk("t6_wall_y", wall_y[31:0], 0);
        rst = 1'b0;
        watch(15);
        chk("t6_no_ack", ack_n.size(), 0);
        chk("t6_no_rnd", nrnd, 0);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge pixel_clk);
            rst = ($urandom_range(0, 399) == 0);
            respawn_req = ($urandom_range(0, 9) == 0) ? NW'($urandom) : '0;
        end
        @(negedge pixel_clk);
        rst = 1'b0;
        respawn_req = '0;
        repeat (200) @(negedge pixel_clk);
        chk("final_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
